// File: rtl/e_mdu_pkg.sv
// e_mdu shared definitions: op codes, default latencies, HI/LO pair type.
// Optional feature macro: MDU_MADD_EN (enables madd/maddu accumulate ops).
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8,
    MDU_MADD  = 4'd9,
    MDU_MADDU = 4'd10
  } mdu_op_e;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  // Ops that occupy the unit for several cycles and raise Busy.
  function automatic logic mdu_is_multi(input logic [3:0] op);
    logic v;
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: v = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU:                    v = 1'b1;
`endif
      default:                                v = 1'b0;
    endcase
    return v;
  endfunction

  function automatic logic mdu_is_div(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// e_mdu_calc: combinational next-{HI,LO} from captured operands and op.
// Divide by zero holds HI/LO; madd/maddu (MDU_MADD_EN) accumulate into {HI,LO}.
module e_mdu_calc
  import e_mdu_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  mdu_op_e     i_op,
  input  hilo_t       i_hilo,
  output hilo_t       o_hilo
);

  logic [63:0] w_prod_s, w_prod_u;
  logic [31:0] w_abs_a, w_abs_b, w_uq, w_ur, w_sq, w_sr;

  // Full 64-bit products; sign extension makes the low 64 bits the signed product.
  assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

  // Signed divide via magnitudes; |0x80000000| fits as unsigned, so the
  // 0x80000000 / -1 case naturally yields 0x80000000 rem 0.
  assign w_abs_a = i_a[31] ? (32'd0 - i_a) : i_a;
  assign w_abs_b = i_b[31] ? (32'd0 - i_b) : i_b;
  assign w_sq    = (i_a[31] ^ i_b[31]) ? (32'd0 - (w_abs_a / w_abs_b)) : (w_abs_a / w_abs_b);
  assign w_sr    = i_a[31] ? (32'd0 - (w_abs_a % w_abs_b)) : (w_abs_a % w_abs_b);
  assign w_uq    = i_a / i_b;
  assign w_ur    = i_a % i_b;

  // Select result per op; anything else (incl. div by zero) holds HI/LO.
  always_comb begin
    o_hilo = i_hilo;
    case (i_op)
      MDU_MULT:  o_hilo = w_prod_s;
      MDU_MULTU: o_hilo = w_prod_u;
      MDU_DIV:   if (i_b != 32'd0) o_hilo = '{hi: w_sr, lo: w_sq};
      MDU_DIVU:  if (i_b != 32'd0) o_hilo = '{hi: w_ur, lo: w_uq};
`ifdef MDU_MADD_EN
      MDU_MADD:  o_hilo = i_hilo + w_prod_s;
      MDU_MADDU: o_hilo = i_hilo + w_prod_u;
`endif
      default:   o_hilo = i_hilo;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// e_mdu: E-stage multiply/divide unit. Owns HI/LO, fixed-latency mult/div,
// mfhi/mflo/mthi/mtlo. Optional feature macro: MDU_MADD_EN (madd/maddu).
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUResult
);

  logic [31:0] r_a, r_b, r_hi, r_lo;
  mdu_op_e     r_op;
  logic [4:0]  r_cnt;
  logic        r_busy;
  hilo_t       w_next;

  e_mdu_calc u_calc (
    .i_a   (r_a),
    .i_b   (r_b),
    .i_op  (r_op),
    .i_hilo('{hi: r_hi, lo: r_lo}),
    .o_hilo(w_next)
  );

  // Capture on Start, count down while busy, commit HI/LO on the last cycle;
  // mthi/mtlo only land while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= MDU_NONE;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else if (r_busy) begin
      r_cnt <= r_cnt - 5'd1;
      if (r_cnt == 5'd1) begin
        r_busy <= 1'b0;
        r_hi   <= w_next.hi;
        r_lo   <= w_next.lo;
      end
    end else if (Start && mdu_is_multi(MDUOp)) begin
      r_a    <= SrcA;
      r_b    <= SrcB;
      r_op   <= mdu_op_e'(MDUOp);
      r_cnt  <= mdu_is_div(MDUOp) ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
      r_busy <= 1'b1;
    end else if (MDUOp == MDU_MTHI) begin
      r_hi <= SrcA;
    end else if (MDUOp == MDU_MTLO) begin
      r_lo <= SrcA;
    end
  end

  // mfhi/mflo read path, zero latency.
  always_comb begin
    MDUResult = '0;
    if (MDUOp == MDU_MFHI)      MDUResult = r_hi;
    else if (MDUOp == MDU_MFLO) MDUResult = r_lo;
  end

  assign Busy = r_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed + randomized checks of e_mdu against a behavioural model.
module tb_e_mdu;
  import e_mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] SrcA = '0, SrcB = '0;
  logic [3:0]  MDUOp = MDU_NONE;
  logic        Start = 1'b0;
  logic        Busy;
  logic [31:0] HI, LO, MDUResult;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .SrcA(SrcA), .SrcB(SrcB), .MDUOp(MDUOp),
    .Start(Start), .Busy(Busy), .HI(HI), .LO(LO), .MDUResult(MDUResult)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic bit madd_on();
`ifdef MDU_MADD_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int exp_cycles(input logic [3:0] op);
    case (op)
      MDU_MULT, MDU_MULTU: return MC;
      MDU_DIV, MDU_DIVU:   return DC;
      MDU_MADD, MDU_MADDU: return madd_on() ? MC : 0;
      default:             return 0;
    endcase
  endfunction

  // Architectural effect of one instruction, written from the ISA rules.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p, acc;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = a; ub = b;
    acc = {m_hi, m_lo};
    case (op)
      MDU_MULT:  begin p = sa * sb; {m_hi, m_lo} = p; end
      MDU_MULTU: begin p = ua * ub; {m_hi, m_lo} = p; end
      MDU_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      MDU_DIVU:  if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      MDU_MTHI:  m_hi = a;
      MDU_MTLO:  m_lo = a;
      MDU_MADD:  if (madd_on()) begin p = sa * sb; acc = acc + p; {m_hi, m_lo} = acc; end
      MDU_MADDU: if (madd_on()) begin p = ua * ub; acc = acc + p; {m_hi, m_lo} = acc; end
      default: ;
    endcase
  endtask

  // Issue one instruction, count Busy cycles (scrambling operands meanwhile), check result.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int n;
    @(negedge clk);
    SrcA = a; SrcB = b; MDUOp = op;
    Start = (exp_cycles(op) > 0) || op == MDU_MADD || op == MDU_MADDU;
    @(negedge clk);
    Start = 1'b0; MDUOp = MDU_NONE;
    n = 0;
    while (Busy && n < 64) begin
      SrcA = $urandom; SrcB = $urandom;
      n++;
      @(negedge clk);
    end
    model(op, a, b);
    chk({tag, "_busy"}, 64'(n), 64'(exp_cycles(op)));
    chk({tag, "_hi"}, {32'd0, HI}, {32'd0, m_hi});
    chk({tag, "_lo"}, {32'd0, LO}, {32'd0, m_lo});
  endtask

  task automatic chk_read();
    @(negedge clk);
    MDUOp = MDU_MFHI; #1 chk("mfhi", {32'd0, MDUResult}, {32'd0, m_hi});
    MDUOp = MDU_MFLO; #1 chk("mflo", {32'd0, MDUResult}, {32'd0, m_lo});
    MDUOp = MDU_NONE; #1 chk("mfnone", {32'd0, MDUResult}, 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin : main
    int n;
    logic [3:0] ops [8];
    ops = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO, MDU_MADD, MDU_MADDU};

    #2;
    chk("rst_busy", {63'd0, Busy}, 64'd0);
    chk("rst_hilo", {HI, LO}, 64'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    // Reset mid-mult aborts and clears HI/LO.
    run_op("pre_hi", MDU_MTHI, 32'hAA, 0);
    run_op("pre_lo", MDU_MTLO, 32'hBB, 0);
    @(negedge clk);
    SrcA = 3; SrcB = 4; MDUOp = MDU_MULT; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; MDUOp = MDU_NONE;
    chk("run_busy", {63'd0, Busy}, 64'd1);
    @(posedge clk); #1 reset_n = 1'b0;
    #1;
    chk("rstmid_busy", {63'd0, Busy}, 64'd0);
    chk("rstmid_hilo", {HI, LO}, 64'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    m_hi = 0; m_lo = 0;
    @(negedge clk); @(negedge clk);
    chk("postrst_busy", {63'd0, Busy}, 64'd0);
    chk("postrst_hilo", {HI, LO}, 64'd0);

    // Directed arithmetic cases.
    run_op("mult", MDU_MULT, 32'hFFFF_FFFE, 3);
    chk("mult_hi_c", {32'd0, HI}, 64'hFFFF_FFFF);
    chk("mult_lo_c", {32'd0, LO}, 64'hFFFF_FFFA);
    run_op("multu", MDU_MULTU, 32'hFFFF_FFFE, 3);
    chk("multu_hi_c", {32'd0, HI}, 64'h2);
    run_op("div", MDU_DIV, 32'hFFFF_FFF9, 2);
    chk("div_c", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divov", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("divov_c", {HI, LO}, 64'h0000_0000_8000_0000);
    run_op("dz_hi", MDU_MTHI, 32'h11, 0);
    run_op("dz_lo", MDU_MTLO, 32'h22, 0);
    run_op("div0", MDU_DIV, 5, 0);
    chk("div0_c", {HI, LO}, 64'h0000_0011_0000_0022);
    run_op("divu0", MDU_DIVU, 9, 0);
    chk_read();

    // Ignore mtlo and a second Start while busy.
    @(negedge clk);
    SrcA = 100; SrcB = 7; MDUOp = MDU_DIV; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; MDUOp = MDU_NONE;
    n = 0;
    while (Busy && n < 64) begin
      n++;
      case (n)
        3: begin MDUOp = MDU_MTLO; SrcA = 32'h55; Start = 1'b0; end
        4: begin MDUOp = MDU_MULT; SrcA = 9; SrcB = 9; Start = 1'b1; end
        default: begin MDUOp = MDU_NONE; Start = 1'b0; end
      endcase
      @(negedge clk);
    end
    MDUOp = MDU_NONE; Start = 1'b0;
    model(MDU_DIV, 100, 7);
    chk("ign_busy", 64'(n), 64'(DC));
    chk("ign_hilo", {HI, LO}, {m_hi, m_lo});
    MDUOp = MDU_MFHI; #1 chk("ign_mfhi", {32'd0, MDUResult}, 64'd2);
    MDUOp = MDU_NONE;

    // Accumulate (or ignored when the feature is absent).
    run_op("ma_hi", MDU_MTHI, 0, 0);
    run_op("ma_lo", MDU_MTLO, 32'hFFFF_FFFF, 0);
    run_op("maddu", MDU_MADDU, 1, 1);
    chk("maddu_c", {HI, LO}, madd_on() ? 64'h0000_0001_0000_0000 : 64'h0000_0000_FFFF_FFFF);

    // Randomized sequence.
    for (int i = 0; i < 60; i++) begin
      logic [3:0] op;
      op = ops[$urandom_range(0, 7)];
      run_op("rnd", op, pick(), pick());
      if (i % 4 == 0) chk_read();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/e_mdu.md
# e_mdu

Multiply/divide unit for the Execute stage, sitting beside the E-stage ALU and fed the same forwarded SrcA/SrcB operands from the D/E pipeline register. It executes mult/multu/div/divu over a fixed multi-cycle latency, owns the architectural HI/LO registers, and serves mfhi/mflo/mthi/mtlo. It exports Busy so the D-stage hazard unit can stall any MDU instruction issued while an operation is in flight.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd/maddu when enabled); legal range 1..31
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..31
- clk  in  1  sole clock; all state updates on rising edge
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- SrcA  in  32  operand A (rs), already forwarded
- SrcB  in  32  operand B (rt), already forwarded
- MDUOp  in  4  operation code (`MDU_*` in const.v); `MDU_none` when the E-stage instruction is not an MDU op
- Start  in  1  high for exactly the cycle a mult/multu/div/divu(/madd/maddu) instruction is in E
- Busy  out  1  operation in flight
- HI  out  32  architectural HI register
- LO  out  32  architectural LO register
- MDUResult  out  32  combinational: HI for mfhi, LO for mflo, else 0

## Operation
- Reset: HI=0, LO=0, Busy=0, internal counter=0, captured operands/op cleared. Reset asserted mid-operation aborts it; HI/LO stay 0 after release.
- Idle (Busy=0), Start=1 with a multi-cycle op: capture SrcA, SrcB, MDUOp; load counter with MULT_CYCLES or DIV_CYCLES; Busy=1 from next cycle.
- Running: counter decrements each cycle; on the edge where counter goes 1->0, HI/LO are written and Busy falls.
- Start while Busy=1: ignored (hazard unit guarantees it never happens; no error state).
- Start=1 with a non-multi-cycle MDUOp: ignored.
- mthi/mtlo while Busy=0: HI (resp. LO) <= SrcA on the next edge. While Busy=1: ignored (stalled upstream).
- mfhi/mflo: MDUResult reflects the current HI/LO; the value is architecturally valid only when Busy=0.
- Arithmetic: mult signed 32x32->64, multu unsigned; HI=upper 32, LO=lower 32.
- div: LO=quotient truncated toward zero, HI=remainder with the dividend's sign; divu unsigned. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (SrcB=0): operation still occupies DIV_CYCLES with Busy=1; HI/LO unchanged at completion.
- Results are computed from captured operands only; SrcA/SrcB changes during Busy have no effect.

## Timing
- Start sampled at edge T0. Busy=1 during cycles T0+1 .. T0+N (N = MULT_CYCLES or DIV_CYCLES), Busy=0 at T0+N+1. New HI/LO are visible from T0+N+1.
- Busy is registered and has no combinational path from Start. The stall condition used by the hazard unit is Start|Busy.
- Back-to-back: a new Start is accepted in the first cycle in which Busy=0.
- mthi/mtlo: single-cycle; write lands at the next edge.
- MDUResult: zero-latency combinational from HI/LO and MDUOp.

## Configuration
- MDU_MADD_EN defined: adds `MDU_madd` (signed) and `MDU_maddu` (unsigned). These perform {HI,LO} <= {HI,LO} + product (64-bit wrap-around), use MULT_CYCLES, and use the same Start/Busy protocol.
- Not defined: those codes are treated as `MDU_none`. Start with them is ignored and Busy stays 0.

## Structure
- const.v holds the `MDU_none`, mult, multu, div, divu, mfhi, mflo, mthi, mtlo, madd and maddu 4-bit op codes, plus the default cycle-count constants.
- One sub-module, e_mdu_calc: purely combinational. It takes the captured operands and op and produces the next {HI,LO}, including the divide-by-zero hold and madd accumulate. e_mdu keeps only the counter, capture registers, HI/LO and Busy.

## Test plan
- Reset mid-mult: Start mult 3*4, drop reset_n at T0+2 -> Busy=0, HI=LO=0 immediately; after release HI=LO=0.
- Signed mult: SrcA=0xFFFFFFFE (-2), SrcB=3, Start -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- Signed div: SrcA=-7, SrcB=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also 0x80000000/-1 -> LO=0x80000000, HI=0.
- Divide by zero: mthi 0x11, mtlo 0x22, then div 5/0 -> Busy 10 cycles; HI=0x11 and LO=0x22 afterwards.
- Ignore-while-busy: Start div, assert mtlo 0x55 and a second Start at T0+3 -> neither takes effect; final HI/LO are the first div's result. mfhi at T0+11 shows the remainder.
- MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then maddu 1*1 -> after 5 cycles HI=1, LO=0. Without the macro, the same stimulus leaves Busy=0 and HI/LO unchanged.
